// File: rtl/dif_radix2_da_pingpong_if.sv
// Stream bundle for the ping-pong reorder buffer: the sample input handshake and
// the reordered output handshake, seen from the producer/consumer (master) or the buffer (slave).
interface dif_radix2_da_pingpong_if #(
  parameter int DATA_WIDTH = 17
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] din_real;
  logic [DATA_WIDTH-1:0] din_imag;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] dout_real;
  logic [DATA_WIDTH-1:0] dout_imag;

  modport master (
    output in_valid, din_real, din_imag, out_ready,
    input  in_ready, out_valid, out_last, dout_real, dout_imag
  );

  modport slave (
    input  in_valid, din_real, din_imag, out_ready,
    output in_ready, out_valid, out_last, dout_real, dout_imag
  );
endinterface

// File: rtl/dif_radix2_da_pingpong.sv
// Two-bank ping-pong frame buffer: frames are written in natural order and read back
// in natural, bit-reversed or stride-N/2 interleaved order chosen per frame.
module dif_radix2_da_pingpong #(
  parameter int DATA_WIDTH = 17,
  parameter int LOG2_N     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  mode,
  dif_radix2_da_pingpong_if.slave bus,
  output logic [15:0] frame_cnt
);
  localparam int N = 1 << LOG2_N;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} BankState;

  BankState              r_bankState [2];
  logic [1:0]            r_bankMode  [2];
  logic                  r_wBank;
  logic                  r_rBank;
  logic [LOG2_N-1:0]     r_wCnt;
  logic [LOG2_N-1:0]     r_rCnt;
  logic [DATA_WIDTH-1:0] r_memRe [2*N];
  logic [DATA_WIDTH-1:0] r_memIm [2*N];
  logic                  r_s1Valid;
  logic                  r_s1Last;
  logic [DATA_WIDTH-1:0] r_s1Re;
  logic [DATA_WIDTH-1:0] r_s1Im;
  logic                  r_outValid;
  logic                  r_outLast;
  logic [DATA_WIDTH-1:0] r_doutRe;
  logic [DATA_WIDTH-1:0] r_doutIm;
  logic [15:0]           r_frameCnt;

  logic                  w_inReady;
  logic                  w_wr;
  logic                  w_outLoad;
  logic                  w_s1Load;
  logic                  w_rd;
  logic [LOG2_N-1:0]     w_rev;
  logic [LOG2_N-1:0]     w_rAddr;

  // Read issue only advances when the bank-read stage can hand its sample onward.
  always_comb begin
    w_inReady = (r_bankState[r_wBank] == EMPTY) || (r_bankState[r_wBank] == FILLING);
    w_wr      = bus.in_valid && w_inReady;
    w_outLoad = !r_outValid || bus.out_ready;
    w_s1Load  = !r_s1Valid || w_outLoad;
    w_rd      = w_s1Load &&
                ((r_bankState[r_rBank] == FULL) || (r_bankState[r_rBank] == DRAINING));
    w_rev = '0;
    for (int i = 0; i < LOG2_N; i++) begin
      w_rev[i] = r_rCnt[LOG2_N-1-i];
    end
    case (r_bankMode[r_rBank])
      2'd1:    w_rAddr = w_rev;
      2'd2:    w_rAddr = {r_rCnt[LOG2_N-2:0], r_rCnt[LOG2_N-1]};
      default: w_rAddr = r_rCnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr && !rst && !flush) begin
      r_memRe[{r_wBank, r_wCnt}] <= bus.din_real;
      r_memIm[{r_wBank, r_wCnt}] <= bus.din_imag;
    end
    if (w_rd) begin
      r_s1Re <= r_memRe[{r_rBank, w_rAddr}];
      r_s1Im <= r_memIm[{r_rBank, w_rAddr}];
    end
  end

  // Write and read never touch the same bank's state on one edge: the write side owns
  // EMPTY/FILLING banks, the read side owns FULL/DRAINING ones.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_bankState[0] <= EMPTY;
      r_bankState[1] <= EMPTY;
      r_bankMode[0]  <= 2'd0;
      r_bankMode[1]  <= 2'd0;
      r_wBank        <= 1'b0;
      r_rBank        <= 1'b0;
      r_wCnt         <= '0;
      r_rCnt         <= '0;
      r_s1Valid      <= 1'b0;
      r_s1Last       <= 1'b0;
      r_outValid     <= 1'b0;
      r_outLast      <= 1'b0;
      if (rst) begin
        r_doutRe   <= '0;
        r_doutIm   <= '0;
        r_frameCnt <= 16'd0;
      end
    end else begin
      if (w_wr) begin
        if (r_bankState[r_wBank] == EMPTY) begin
          r_bankMode[r_wBank] <= mode;
        end
        if (&r_wCnt) begin
          r_bankState[r_wBank] <= FULL;
          r_wCnt               <= '0;
          r_wBank              <= ~r_wBank;
        end else begin
          r_bankState[r_wBank] <= FILLING;
          r_wCnt               <= r_wCnt + 1'b1;
        end
      end
      if (w_rd) begin
        if (&r_rCnt) begin
          r_bankState[r_rBank] <= EMPTY;
          r_rCnt               <= '0;
          r_rBank              <= ~r_rBank;
        end else begin
          r_bankState[r_rBank] <= DRAINING;
          r_rCnt               <= r_rCnt + 1'b1;
        end
      end
      if (w_s1Load) begin
        r_s1Valid <= w_rd;
        r_s1Last  <= w_rd && (&r_rCnt);
      end
      if (w_outLoad) begin
        r_outValid <= r_s1Valid;
        r_outLast  <= r_s1Last;
        if (r_s1Valid) begin
          r_doutRe <= r_s1Re;
          r_doutIm <= r_s1Im;
        end
      end
      if (r_outValid && bus.out_ready && r_outLast) begin
        r_frameCnt <= r_frameCnt + 16'd1;
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_last  = r_outLast;
  assign bus.dout_real = r_doutRe;
  assign bus.dout_imag = r_doutIm;
  assign frame_cnt     = r_frameCnt;
endmodule

// File: tb/tb_dif_radix2_da_pingpong.sv
// Scoreboard bench for the ping-pong reorder buffer with 8-sample frames: a frame-level
// reference model queues the expected reordered stream, a monitor checks every output.
module tb_dif_radix2_da_pingpong;
  localparam int DW = 17;
  localparam int L  = 3;
  localparam int N  = 1 << L;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } Sample;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  mode  = 2'd0;
  logic [15:0] frame_cnt;

  dif_radix2_da_pingpong_if #(.DATA_WIDTH(DW)) bus ();

  dif_radix2_da_pingpong #(.DATA_WIDTH(DW), .LOG2_N(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .mode      (mode),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int         checks      = 0;
  int         errors      = 0;
  int         modelFrames = 0;
  int         readyMode   = 0;
  int         acceptCnt   = 0;
  int         inStalls    = 0;
  Sample      expQ[$];
  Sample      curFrame[$];
  logic [1:0] curMode     = 2'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Position in the written frame that is emitted k-th for a given read order.
  function automatic int refIndex(input logic [1:0] m, input int k);
    int r;
    int v;
    r = 0;
    v = k;
    case (m)
      2'd1: begin
        for (int b = 0; b < L; b++) begin
          r = r * 2 + v % 2;
          v = v / 2;
        end
        return r;
      end
      2'd2:    return (k < N / 2) ? 2 * k : 2 * (k - N / 2) + 1;
      default: return k;
    endcase
  endfunction

  task automatic applyStimulus(input int nSamples, input bit ramp, input logic [1:0] m0,
                               input int switchIdx, input logic [1:0] m1, input int gapPct);
    int  waited;
    bit  accepted;
    for (int i = 0; i < nSamples; i++) begin
      while (gapPct > 0 && $urandom_range(99) < gapPct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      mode         = (i < switchIdx) ? m0 : m1;
      bus.in_valid = 1'b1;
      bus.din_real = ramp ? DW'(i) : DW'($urandom);
      bus.din_imag = ramp ? DW'(i + 100) : DW'($urandom);
      waited   = 0;
      accepted = 1'b0;
      while (!accepted) begin
        accepted = bus.in_ready;
        if (!accepted) inStalls++;
        @(posedge clk); #1;
        waited++;
        if (!accepted && waited > 400) begin
          checkOutput("inputAcceptTimeout", 32'd0, 32'd1);
          bus.in_valid = 1'b0;
          return;
        end
      end
      acceptCnt++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    if (expQ.size() != 0) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic watchBubbles(input int n);
    int w;
    int gaps;
    w    = 0;
    gaps = 0;
    while (!bus.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.out_valid) begin
      checkOutput("bubbleWatchTimeout", 32'd0, 32'd1);
    end else begin
      for (int i = 1; i < n; i++) begin
        @(negedge clk);
        if (!bus.out_valid) gaps++;
      end
      checkOutput("noOutputBubble", 32'(gaps), 32'd0);
    end
  endtask

  initial begin : readyDriver
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (readyMode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  initial begin : monitor
    Sample s;
    Sample e;
    Sample held;
    bit    prevStall;
    prevStall = 1'b0;
    held.re   = '0;
    held.im   = '0;
    held.last = 1'b0;
    forever begin
      @(negedge clk);
      checkOutput("frameCnt", 32'(frame_cnt), 32'(modelFrames));
      if (rst || flush) begin
        expQ.delete();
        curFrame.delete();
        prevStall = 1'b0;
        if (rst) modelFrames = 0;
      end else begin
        if (prevStall) begin
          checkOutput("stallValid", 32'(bus.out_valid), 32'd1);
          checkOutput("stallReal", 32'(bus.dout_real), 32'(held.re));
          checkOutput("stallImag", 32'(bus.dout_imag), 32'(held.im));
          checkOutput("stallLast", 32'(bus.out_last), 32'(held.last));
        end
        if (bus.in_valid && bus.in_ready) begin
          s.re   = bus.din_real;
          s.im   = bus.din_imag;
          s.last = 1'b0;
          if (curFrame.size() == 0) curMode = mode;
          curFrame.push_back(s);
          if (curFrame.size() == N) begin
            for (int k = 0; k < N; k++) begin
              e      = curFrame[refIndex(curMode, k)];
              e.last = (k == N - 1);
              expQ.push_back(e);
            end
            curFrame.delete();
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedOutput", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("doutReal", 32'(bus.dout_real), 32'(e.re));
            checkOutput("doutImag", 32'(bus.dout_imag), 32'(e.im));
            checkOutput("outLast", 32'(bus.out_last), 32'(e.last));
            if (e.last) modelFrames++;
          end
        end
        prevStall = bus.out_valid && !bus.out_ready;
        held.re   = bus.dout_real;
        held.im   = bus.dout_imag;
        held.last = bus.out_last;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin : stimulus
    int base;
    int framesBefore;
    int spurious;
    bus.in_valid = 1'b0;
    bus.din_real = '0;
    bus.din_imag = '0;
    repeat (2) @(posedge clk); #1;
    checkOutput("resetInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("resetOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("resetOutLast", 32'(bus.out_last), 32'd0);
    checkOutput("resetDoutReal", 32'(bus.dout_real), 32'd0);
    checkOutput("resetDoutImag", 32'(bus.dout_imag), 32'd0);
    checkOutput("resetFrameCnt", 32'(frame_cnt), 32'd0);
    rst       = 1'b0;
    readyMode = 1;
    @(posedge clk); #1;

    $display("[TB] bit-reversed ramp frame and latency");
    applyStimulus(N, 1'b1, 2'd1, N, 2'd1, 0);
    checkOutput("latencyEdge0", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("latencyEdge1", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("latencyEdge2", 32'(bus.out_valid), 32'd1);
    waitDrain(100);
    checkOutput("frameCntFirst", 32'(frame_cnt), 32'd1);

    $display("[TB] interleaved ramp frame");
    applyStimulus(N, 1'b1, 2'd2, N, 2'd2, 0);
    waitDrain(100);
    checkOutput("frameCntSecond", 32'(frame_cnt), 32'd2);

    $display("[TB] back-to-back streaming");
    base = inStalls;
    fork
      begin
        for (int f = 0; f < 4; f++) applyStimulus(N, 1'b0, 2'(f), N, 2'(f), 0);
      end
      watchBubbles(4 * N);
    join
    checkOutput("noInputStall", 32'(inStalls - base), 32'd0);
    waitDrain(100);

    $display("[TB] output blocked while three frames are offered");
    readyMode = 0;
    @(posedge clk); #1;
    base = acceptCnt;
    fork
      begin
        for (int f = 0; f < 3; f++) applyStimulus(N, 1'b0, 2'd0, N, 2'd0, 0);
      end
      begin
        repeat (40) @(posedge clk);
        #3;
        checkOutput("acceptsWhileBlocked", 32'(acceptCnt - base), 32'(2 * N));
        checkOutput("inReadyWhileBlocked", 32'(bus.in_ready), 32'd0);
        readyMode = 1;
      end
    join
    waitDrain(200);
    checkOutput("thirdFrameAccepted", 32'(acceptCnt - base), 32'(3 * N));

    $display("[TB] mode change in mid-frame");
    applyStimulus(N, 1'b0, 2'd0, 3, 2'd1, 0);
    applyStimulus(N, 1'b0, 2'd1, N, 2'd1, 0);
    waitDrain(200);

    $display("[TB] flush during drain");
    readyMode = 0;
    @(posedge clk); #1;
    applyStimulus(N, 1'b0, 2'd0, N, 2'd0, 0);
    applyStimulus(N, 1'b0, 2'd0, N, 2'd0, 0);
    readyMode = 1;
    repeat (3) @(posedge clk);
    #1;
    readyMode = 0;
    repeat (3) @(posedge clk);
    #1;
    framesBefore = modelFrames;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flushOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("flushOutLast", 32'(bus.out_last), 32'd0);
    checkOutput("flushInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("flushFrameCnt", 32'(frame_cnt), 32'(framesBefore));
    readyMode = 1;
    applyStimulus(N, 1'b0, 2'd2, N, 2'd2, 0);
    waitDrain(100);
    checkOutput("postFlushFrameCnt", 32'(frame_cnt), 32'(framesBefore + 1));

    $display("[TB] random backpressure and input gaps");
    readyMode = 2;
    for (int f = 0; f < 6; f++) begin
      applyStimulus(N, 1'b0, 2'($urandom_range(3)), N, 2'd0, 30);
    end
    waitDrain(400);
    readyMode = 1;

    $display("[TB] reset in mid-frame");
    readyMode = 0;
    @(posedge clk); #1;
    applyStimulus(N, 1'b0, 2'd1, N, 2'd1, 0);
    applyStimulus(3, 1'b0, 2'd0, 3, 2'd0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midResetOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midResetInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("midResetDoutReal", 32'(bus.dout_real), 32'd0);
    checkOutput("midResetFrameCnt", 32'(frame_cnt), 32'd0);
    rst       = 1'b0;
    readyMode = 1;
    spurious  = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) spurious++;
    end
    checkOutput("noOutputAfterReset", 32'(spurious), 32'd0);
    @(posedge clk); #1;
    applyStimulus(N, 1'b0, 2'd1, N, 2'd1, 0);
    waitDrain(100);
    checkOutput("frameCntAfterReset", 32'(frame_cnt), 32'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dif_radix2_da_pingpong.md
DIF_RADIX2_DA_PINGPONG -- requirements
Module: dif_radix2_da_pingpong

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 17, giving the bit width of each real and imaginary sample.
REQ-002 The block SHALL have parameter LOG2_N, default 6, setting the frame length N = 2^LOG2_N; legal range 2..12.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous abort of all buffered frames.
REQ-006 The block SHALL have port mode, input, 2 bits: read order, where 0 = natural, 1 = bit-reversed, 2 = rotate-left-by-1 (stride N/2 interleave), 3 = reserved and treated as 0.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-009 The block SHALL have ports din_real and din_imag, input, DATA_WIDTH each: input sample.
REQ-010 The block SHALL have port out_valid, output, 1 bit: output sample valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output sample.
REQ-012 The block SHALL have ports dout_real and dout_imag, output, DATA_WIDTH each: output sample.
REQ-013 The block SHALL have port out_last, output, 1 bit: high with the final (N-1th) output sample of a frame.
REQ-014 The block SHALL have port frame_cnt, output, 16 bits: count of completed output frames, wrapping modulo 2^16.

Function
REQ-015 The block SHALL contain two banks (bank 0, bank 1), each holding N complex samples, each with its own state: EMPTY, FILLING, FULL, or DRAINING.
REQ-016 An input transfer SHALL occur on an edge where in_valid && in_ready; the sample SHALL be written at write index wcnt (0..N-1, natural order) of the current write bank.
REQ-017 in_ready SHALL be high iff the current write bank is EMPTY or FILLING, with no combinational path from in_valid.
REQ-018 The first write into an EMPTY bank SHALL move it to FILLING and latch mode for that frame; a mode change mid-frame SHALL NOT affect that frame.
REQ-019 Writing index N-1 SHALL move the bank to FULL, wrap wcnt to 0, and toggle the write bank pointer.
REQ-020 The read side SHALL take the FULL bank whose fill completed earliest, move it to DRAINING, and issue read index rcnt = 0..N-1.
REQ-021 The bank address for each rcnt SHALL depend on the latched mode: natural = rcnt; bit-reversed = rcnt with its LOG2_N bits reversed; rotate-left = {rcnt[LOG2_N-2:0], rcnt[LOG2_N-1]}.
REQ-022 The output register SHALL load when out_valid is low or out_ready is high.
REQ-023 dout_real, dout_imag, out_valid and out_last SHALL be registered and held stable while out_valid && !out_ready.
REQ-024 Latency: if the read side is idle, out_valid SHALL rise on the second edge after the edge that writes index N-1 (one cycle for bank read, one cycle for the output register).
REQ-025 Back-to-back frames SHALL stream with no bubbles when in_valid and out_ready are held high continuously.
REQ-026 Issuing read index N-1 SHALL return the bank to EMPTY in the same cycle, so a write stalled on that bank resumes the next cycle.
REQ-027 When read N-1 and write N-1 target opposite banks on the same edge, both transitions SHALL apply, with no lost or duplicated frame.
REQ-028 frame_cnt SHALL increment on each output transfer with out_last high.
REQ-029 flush SHALL on the next edge set both banks to EMPTY, clear wcnt, rcnt, out_valid and out_last, and reset the bank pointers to bank 0.
REQ-030 flush SHALL preserve frame_cnt, and frame data SHALL NOT be corrupted by the flush.
REQ-031 Bank storage content SHALL be unreset and SHALL be irrelevant while the bank is EMPTY.

Reset
REQ-032 On rst high at a clock edge, all state SHALL return to the post-flush state, and additionally frame_cnt SHALL be 0.
REQ-033 On rst high at a clock edge, in_ready SHALL be 1 in the cycle after the rst edge, with out_valid = 0, out_last = 0, dout_real = 0 and dout_imag = 0.
REQ-034 rst asserted mid-frame SHALL discard all partial and full frames, and no out_valid SHALL appear until a new complete frame has been written.

Verification
REQ-035 Scenario (LOG2_N=3, mode=1, in_valid and out_ready always high): input ramp 0..7 -> output 0,4,2,6,1,5,3,7, with out_last on 7 and frame_cnt = 1.
REQ-036 Scenario (LOG2_N=3, mode=2): input 0..7 -> output 0,2,4,6,1,3,5,7.
REQ-037 Scenario (mode=0): out_ready held low while 3 frames are offered -> in_ready drops after 16 accepts; release out_ready -> two frames emerge intact, in order, and the third frame is accepted.
REQ-038 Scenario: mode is toggled 0 -> 1 at input index 3 -> that frame is natural order, and the next frame is bit-reversed.
REQ-039 Scenario: flush asserted mid-drain with bank 1 FULL -> next cycle out_valid = 0 and in_ready = 1; a new frame emerges correctly and frame_cnt is unchanged by the flush.
REQ-040 Scenario: out_ready randomly toggled at 50 % -> the stream matches the reference permutation and dout is stable during every stall cycle.
